// File: rtl/cpu_exec_sequencer_if.sv
// Program-memory read bus between the execution sequencer (master) and a
// synchronous instruction memory (slave).
interface cpu_exec_sequencer_if #(
    parameter int PC_W = 8
);
    logic            imem_en;
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     imem_rdata;

    modport master (output imem_en, output imem_addr, input imem_rdata);
    modport slave  (input imem_en, input imem_addr, output imem_rdata);
endinterface

// File: rtl/cpu_exec_sequencer.sv
// Multi-cycle fetch/wait/decode/execute controller owning PC, IR, a 32x16 GPR
// file and SGPR; runs under a start/done handshake until HALT or illegal op.
module cpu_exec_sequencer #(
    parameter int          PC_W     = 8,
    parameter int unsigned START_PC = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    cpu_exec_sequencer_if.master  imem,
    output logic                  busy,
    output logic                  done,
    output logic                  illegal,
    output logic [PC_W-1:0]       pc,
    output logic [15:0]           sgpr,
    input  logic [4:0]            dbg_addr,
    output logic [15:0]           dbg_data
);
    localparam logic [PC_W-1:0] START_PC_C = PC_W'(START_PC);

    localparam logic [4:0] OP_MOVSGPR = 5'b00000;
    localparam logic [4:0] OP_MOV     = 5'b00001;
    localparam logic [4:0] OP_ADD     = 5'b00010;
    localparam logic [4:0] OP_SUB     = 5'b00011;
    localparam logic [4:0] OP_MUL     = 5'b00100;
    localparam logic [4:0] OP_HALT    = 5'b11111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_WAIT   = 3'd2,
        S_DECODE = 3'd3,
        S_EXEC   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t          state_r;
    logic [PC_W-1:0] pc_r;
    logic [31:0]     ir_r;
    logic [15:0]     gpr_r [32];
    logic [15:0]     sgpr_r;
    logic            imem_en_r;
    logic            busy_r;
    logic            done_r;
    logic            illegal_r;

    logic [4:0]      op_s;
    logic [4:0]      rdst_s;
    logic [15:0]     isrc_s;
    logic            imm_mode_s;
    logic [15:0]     op_a_s;
    logic [15:0]     op_b_s;
    logic [31:0]     prod_s;
    logic [15:0]     result_s;
    logic            exec_op_s;

    assign op_s       = ir_r[31:27];
    assign rdst_s     = ir_r[26:22];
    assign imm_mode_s = ir_r[16];
    assign isrc_s     = ir_r[15:0];

    // Operand fetch and result selection from the pre-writeback register state.
    always_comb begin
        op_a_s    = gpr_r[ir_r[21:17]];
        op_b_s    = imm_mode_s ? isrc_s : gpr_r[ir_r[15:11]];
        prod_s    = 32'(op_a_s) * 32'(op_b_s);
        result_s  = 16'h0000;
        exec_op_s = 1'b1;
        case (op_s)
            OP_MOVSGPR: result_s = sgpr_r;
            OP_MOV:     result_s = imm_mode_s ? isrc_s : op_a_s;
            OP_ADD:     result_s = op_a_s + op_b_s;
            OP_SUB:     result_s = op_a_s - op_b_s;
            OP_MUL:     result_s = prod_s[15:0];
            default:    exec_op_s = 1'b0;
        endcase
    end

    // Control FSM with architectural state and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            pc_r      <= START_PC_C;
            ir_r      <= 32'h0000_0000;
            sgpr_r    <= 16'h0000;
            imem_en_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            illegal_r <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                gpr_r[i] <= 16'h0000;
            end
        end else begin
            imem_en_r <= 1'b0;
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        pc_r      <= START_PC_C;
                        illegal_r <= 1'b0;
                        done_r    <= 1'b0;
                        busy_r    <= 1'b1;
                        imem_en_r <= 1'b1;
                        state_r   <= S_FETCH;
                    end
                end
                S_FETCH: state_r <= S_WAIT;
                S_WAIT: begin
                    ir_r    <= imem.imem_rdata;
                    state_r <= S_DECODE;
                end
                S_DECODE: begin
                    if (op_s == OP_HALT) begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= S_DONE;
                    end else if (!exec_op_s) begin
                        illegal_r <= 1'b1;
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                        state_r   <= S_DONE;
                    end else begin
                        state_r <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    gpr_r[rdst_s] <= result_s;
                    if (op_s == OP_MUL) begin
                        sgpr_r <= prod_s[31:16];
                    end
                    pc_r      <= pc_r + PC_W'(1);
                    imem_en_r <= 1'b1;
                    state_r   <= S_FETCH;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign imem.imem_en   = imem_en_r;
    assign imem.imem_addr = pc_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign illegal        = illegal_r;
    assign pc             = pc_r;
    assign sgpr           = sgpr_r;
    assign dbg_data       = gpr_r[dbg_addr];

endmodule

// File: tb/tb_cpu_exec_sequencer.sv
// Randomized and directed self-checking bench for cpu_exec_sequencer against
// an instruction-level reference model of the program.
module tb_cpu_exec_sequencer;
    localparam int PW = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, illegal;
    logic [PW-1:0] pc;
    logic [15:0] sgpr;
    logic [4:0]  dbg_addr = 5'd0;
    logic [15:0] dbg_data;

    logic        start2 = 1'b0;
    logic        busy2, done2, illegal2;
    logic [1:0]  pc2;
    logic [15:0] sgpr2;
    logic [4:0]  dbg_addr2 = 5'd0;
    logic [15:0] dbg_data2;

    logic [31:0] mem  [16];
    logic [31:0] mem2 [4];
    logic [15:0] m_gpr [32];
    logic [15:0] m_sgpr;

    int n_checks = 0;
    int n_pass   = 0;

    cpu_exec_sequencer_if #(.PC_W(PW)) bus ();
    cpu_exec_sequencer_if #(.PC_W(2))  bus2 ();

    cpu_exec_sequencer #(.PC_W(PW), .START_PC(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .imem(bus.master),
        .busy(busy), .done(done), .illegal(illegal), .pc(pc), .sgpr(sgpr),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    cpu_exec_sequencer #(.PC_W(2), .START_PC(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .imem(bus2.master),
        .busy(busy2), .done(done2), .illegal(illegal2), .pc(pc2), .sgpr(sgpr2),
        .dbg_addr(dbg_addr2), .dbg_data(dbg_data2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.imem_en)  bus.imem_rdata  <= mem[bus.imem_addr];
        if (bus2.imem_en) bus2.imem_rdata <= mem2[bus2.imem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] enc(input int op, input int rd, input int rs1,
                                        input bit imm, input int rs2, input int isrc);
        logic [31:0] w;
        w = {5'(op), 5'(rd), 5'(rs1), imm, 16'h0000};
        if (imm) w[15:0] = 16'(isrc);
        else     w[15:11] = 5'(rs2);
        return w;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = enc(31, 0, 0, 1'b0, 0, 0);
    endtask

    // Instruction-level model: walks the program from address 0 until HALT/illegal.
    task automatic model_run(output int steps, output int end_pc, output bit ill);
        int p;
        logic [31:0] w;
        logic [15:0] a, b;
        logic [31:0] prod;
        int op;
        p = 0; steps = 0; ill = 1'b0;
        for (int guard = 0; guard < 64; guard++) begin
            w  = mem[p];
            op = int'(w[31:27]);
            if (op == 31) break;
            if (op > 4) begin ill = 1'b1; break; end
            a = m_gpr[w[21:17]];
            b = w[16] ? w[15:0] : m_gpr[w[15:11]];
            case (op)
                0: m_gpr[w[26:22]] = m_sgpr;
                1: m_gpr[w[26:22]] = w[16] ? w[15:0] : a;
                2: m_gpr[w[26:22]] = 16'((32'(a) + 32'(b)) % 65536);
                3: m_gpr[w[26:22]] = 16'((32'(a) + 65536 - 32'(b)) % 65536);
                default: begin
                    prod = 32'(a) * 32'(b);
                    m_gpr[w[26:22]] = 16'(prod % 65536);
                    m_sgpr = 16'(prod / 65536);
                end
            endcase
            steps++;
            p = (p + 1) % 16;
        end
        end_pc = p;
    endtask

    task automatic read_gpr(input int r, output logic [15:0] v);
        dbg_addr = 5'(r);
        #1;
        v = dbg_data;
    endtask

    task automatic check_all_gpr(input string tag);
        logic [15:0] v;
        for (int r = 0; r < 32; r++) begin
            read_gpr(r, v);
            check($sformatf("%s_gpr%0d", tag, r), 32'(v), 32'(m_gpr[r]));
        end
    endtask

    // Launches the program in mem, optionally pokes start mid-run, checks the end state.
    task automatic run_prog(input string tag, input bit poke, output int cyc);
        int steps, epc;
        bit eill;
        model_run(steps, epc, eill);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check({tag, "_busy_on"}, 32'(busy), 32'd1);
        check({tag, "_ill_clr"}, 32'(illegal), 32'd0);
        cyc = 0;
        while (cyc < 300) begin
            @(posedge clk);
            cyc++;
            #1;
            start = 1'b0;
            if (done) break;
            if (poke && cyc == 5) start = 1'b1;
        end
        start = 1'b0;
        check({tag, "_cycles"}, 32'(cyc), 32'(4 * steps + 3));
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_off"}, 32'(busy), 32'd0);
        check({tag, "_illegal"}, 32'(illegal), 32'(eill));
        check({tag, "_pc"}, 32'(pc), 32'(epc));
        check({tag, "_sgpr"}, 32'(sgpr), 32'(m_sgpr));
        check_all_gpr(tag);
    endtask

    initial begin
        int cyc;
        logic [15:0] v;
        for (int r = 0; r < 32; r++) m_gpr[r] = 16'h0000;
        m_sgpr = 16'h0000;
        clear_mem();
        for (int i = 0; i < 4; i++) mem2[i] = enc(31, 0, 0, 1'b0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_pc2", 32'(pc2), 32'd3);
        check("rst_en", 32'(bus.imem_en), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_stays", 32'(busy), 32'd0);
        check_all_gpr("rst");

        // Basic sequence
        mem[0] = enc(1, 1, 0, 1'b1, 0, 5);
        mem[1] = enc(1, 2, 0, 1'b1, 0, 7);
        mem[2] = enc(2, 3, 1, 1'b0, 2, 0);
        run_prog("basic", 1'b0, cyc);
        check("basic_15clk", 32'(cyc), 32'd15);
        read_gpr(3, v);
        check("basic_r3", 32'(v), 32'd12);

        // MUL and MOVSGPR
        clear_mem();
        mem[0] = enc(1, 1, 0, 1'b1, 0, 16'h1234);
        mem[1] = enc(1, 2, 0, 1'b1, 0, 16'h0100);
        mem[2] = enc(4, 4, 1, 1'b0, 2, 0);
        mem[3] = enc(0, 5, 0, 1'b0, 0, 0);
        run_prog("mul", 1'b0, cyc);
        read_gpr(4, v);
        check("mul_r4", 32'(v), 32'h3400);
        read_gpr(5, v);
        check("mul_r5", 32'(v), 32'h0012);
        check("mul_sgpr", 32'(sgpr), 32'h0012);

        // Modulo wrap and rdst == rsrc1
        clear_mem();
        mem[0] = enc(1, 1, 0, 1'b1, 0, 16'hFFFF);
        mem[1] = enc(2, 2, 1, 1'b1, 0, 2);
        mem[2] = enc(3, 3, 2, 1'b1, 0, 3);
        mem[3] = enc(2, 1, 1, 1'b1, 0, 1);
        run_prog("wrap", 1'b1, cyc);
        read_gpr(2, v); check("wrap_r2", 32'(v), 32'h0001);
        read_gpr(3, v); check("wrap_r3", 32'(v), 32'hFFFE);
        read_gpr(1, v); check("wrap_r1", 32'(v), 32'h0000);

        // Illegal opcode, then a fresh start clears the sticky flag
        clear_mem();
        mem[0] = enc(1, 6, 0, 1'b1, 0, 16'h0055);
        mem[1] = 32'h5000_0000;
        mem[2] = enc(1, 7, 0, 1'b1, 0, 16'h0099);
        run_prog("ill", 1'b0, cyc);
        check("ill_flag", 32'(illegal), 32'd1);
        check("ill_pc", 32'(pc), 32'd1);
        clear_mem();
        run_prog("ill_clear", 1'b0, cyc);

        // Full 16-word program reaching HALT at the last address
        for (int i = 0; i < 15; i++) mem[i] = enc(2, 8, 8, 1'b1, 0, i + 1);
        mem[15] = enc(31, 0, 0, 1'b0, 0, 0);
        run_prog("full", 1'b1, cyc);

        // Randomized programs
        for (int t = 0; t < 25; t++) begin
            int len;
            clear_mem();
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                int isrc;
                isrc = ($urandom_range(0, 3) == 0) ? 16'hFFFF : int'($urandom_range(0, 65535));
                mem[i] = enc($urandom_range(0, 4), $urandom_range(0, 7), $urandom_range(0, 7),
                             1'($urandom_range(0, 1)), $urandom_range(0, 7), isrc);
            end
            if ($urandom_range(0, 4) == 0) mem[len] = enc($urandom_range(5, 30), 0, 0, 1'b0, 0, 0);
            run_prog($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), cyc);
        end

        // PC wrap on the 4-word instance starting at address 3
        mem2[3] = enc(1, 1, 0, 1'b1, 0, 9);
        mem2[0] = enc(1, 2, 0, 1'b1, 0, 10);
        mem2[1] = enc(31, 0, 0, 1'b0, 0, 0);
        start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        cyc = 0;
        while (cyc < 100) begin
            @(posedge clk);
            cyc++;
            #1;
            if (done2) break;
        end
        check("pcw_cycles", 32'(cyc), 32'd11);
        check("pcw_pc", 32'(pc2), 32'd1);
        dbg_addr2 = 5'd1; #1;
        check("pcw_r1", 32'(dbg_data2), 32'd9);
        dbg_addr2 = 5'd2; #1;
        check("pcw_r2", 32'(dbg_data2), 32'd10);

        // Reset during EXEC of an ADD aborts with everything cleared
        clear_mem();
        mem[0] = enc(2, 9, 9, 1'b1, 0, 3);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int r = 0; r < 32; r++) m_gpr[r] = 16'h0000;
        m_sgpr = 16'h0000;
        check("rexec_busy", 32'(busy), 32'd0);
        check("rexec_done", 32'(done), 32'd0);
        check("rexec_pc", 32'(pc), 32'd0);
        check("rexec_sgpr", 32'(sgpr), 32'd0);
        check_all_gpr("rexec");
        @(posedge clk);
        #1;
        check("rexec_idle", 32'(busy), 32'd0);
        run_prog("post_rst", 1'b0, cyc);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
